mem_arbiter: RTL and testbench

//  Shares one unified memory port between instruction fetch (I) and load/store (D).

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_watchdog.sv | 30 +++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DBUSY = 2'd1,
    ARB_IBUSY = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  function automatic logic is_busy(input arb_state_t s);
    return (s != ARB_IDLE);
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Busy-cycle counter that flags the last cycle a transaction may wait for mem_ready.
module mem_arbiter_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wd_cnt;

  // Count busy cycles; clearing while idle means every new transaction starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (clear) begin
      wd_cnt <= '0;
    end else if (enable) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign expired = enable & (wd_cnt == TERMINAL);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and load/store,
// one access per requester per pipeline cycle, with a watchdog against hung memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                imem_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                dmem_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                mem_err
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state;
  arb_state_t next_state;

  logic              i_done;
  logic              d_done;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [BE_W-1:0]   lat_be;
  logic [DATA_W-1:0] lat_wdata;

  logic busy;
  logic wd_expired;
  logic complete;
  logic timeout_hit;
  logic advance;

  assign imem_stall  = i_req & ~i_done;
  assign dmem_stall  = d_req & ~d_done;
  assign advance     = ~imem_stall & ~dmem_stall;
  assign busy        = is_busy(state);
  assign complete    = busy & (mem_ready | wd_expired);
  assign timeout_hit = busy & ~mem_ready & wd_expired;

  mem_arbiter_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (~busy),
    .enable (busy),
    .expired(wd_expired)
  );

  // State register; reset drops straight to idle so mem_req falls immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant the data side first (older instruction), then fetch; return to idle on completion.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (dmem_stall) begin
          next_state = ARB_DBUSY;
        end else if (imem_stall) begin
          next_state = ARB_IBUSY;
        end
      end
      ARB_DBUSY, ARB_IBUSY: begin
        if (complete) begin
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Memory port is driven only while a transaction is outstanding, quiet otherwise.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (busy) begin
      mem_req   = 1'b1;
      mem_we    = lat_we;
      mem_be    = lat_be;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
    end
  end

  // Capture the granted request on leaving idle so the port stays stable while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
    end else if (state == ARB_IDLE) begin
      if (dmem_stall) begin
        lat_addr  <= d_addr;
        lat_we    <= d_we;
        lat_be    <= d_be;
        lat_wdata <= d_wdata;
      end else if (imem_stall) begin
        lat_addr  <= i_addr;
        lat_we    <= 1'b0;
        lat_be    <= '1;
        lat_wdata <= '0;
      end
    end
  end

  // Done flags: cleared when the pipeline advances, set on completion only if still requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (advance) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
      if (complete && state == ARB_DBUSY && d_req) begin
        d_done <= 1'b1;
      end
      if (complete && state == ARB_IBUSY && i_req) begin
        i_done <= 1'b1;
      end
    end
  end

  // Read data holding registers; a timed-out read returns zero, stores leave d_rdata alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (complete) begin
      if (state == ARB_DBUSY && !lat_we) begin
        d_rdata <= timeout_hit ? '0 : mem_rdata;
      end
      if (state == ARB_IBUSY) begin
        i_rdata <= timeout_hit ? '0 : mem_rdata;
      end
    end
  end

  // Sticky error flag raised by any watchdog expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_err <= 1'b0;
    end else if (timeout_hit) begin
      mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              imem_stall;
  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              dmem_stall;
  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_err;

  mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .imem_stall(imem_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .dmem_stall(dmem_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: who owns the port, how long it has waited, per-requester served flags.
  int          m_owner;
  int          m_wait;
  bit          m_i_done;
  bit          m_d_done;
  bit          m_err;
  bit          m_last_adv;
  logic [31:0] m_i_rdata;
  logic [31:0] m_d_rdata;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_we;
  logic [3:0]  m_be;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic void model_reset();
    m_owner    = 0;
    m_wait     = 0;
    m_i_done   = 1'b0;
    m_d_done   = 1'b0;
    m_err      = 1'b0;
    m_last_adv = 1'b1;
    m_i_rdata  = '0;
    m_d_rdata  = '0;
    m_addr     = '0;
    m_wdata    = '0;
    m_we       = 1'b0;
    m_be       = '0;
  endfunction

  function automatic void model_step();
    bit          want_i;
    bit          want_d;
    bit          adv;
    logic [31:0] data;
    want_i = i_req && !m_i_done;
    want_d = d_req && !m_d_done;
    adv    = !want_i && !want_d;
    m_last_adv = adv;
    if (adv) begin
      m_i_done = 1'b0;
      m_d_done = 1'b0;
    end
    if (m_owner == 0) begin
      if (want_d) begin
        m_owner = 1;
        m_wait  = 0;
        m_addr  = d_addr;
        m_we    = d_we;
        m_be    = d_be;
        m_wdata = d_wdata;
      end else if (want_i) begin
        m_owner = 2;
        m_wait  = 0;
        m_addr  = i_addr;
        m_we    = 1'b0;
        m_be    = 4'hF;
        m_wdata = '0;
      end
    end else if (mem_ready || m_wait == TIMEOUT - 1) begin
      data = mem_ready ? mem_rdata : 32'h0;
      if (m_owner == 1) begin
        if (!m_we) m_d_rdata = data;
        if (d_req) m_d_done = 1'b1;
      end else begin
        m_i_rdata = data;
        if (i_req) m_i_done = 1'b1;
      end
      if (!mem_ready) m_err = 1'b1;
      m_owner = 0;
    end else begin
      m_wait++;
    end
  endfunction

  task automatic compare_all();
    check_output("mem_req", 32'(mem_req), 32'(m_owner != 0));
    if (m_owner != 0) begin
      check_output("mem_addr", mem_addr, m_addr);
      check_output("mem_we", 32'(mem_we), 32'(m_we));
      check_output("mem_be", 32'(mem_be), 32'(m_be));
      if (m_we) check_output("mem_wdata", mem_wdata, m_wdata);
    end
    check_output("imem_stall", 32'(imem_stall), 32'(i_req && !m_i_done));
    check_output("dmem_stall", 32'(dmem_stall), 32'(d_req && !m_d_done));
    check_output("i_rdata", i_rdata, m_i_rdata);
    check_output("d_rdata", d_rdata, m_d_rdata);
    check_output("mem_err", 32'(mem_err), 32'(m_err));
  endtask

  task automatic apply_stimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [3:0] db, input logic [31:0] da,
                                input logic [31:0] dd, input logic rdy, input logic [31:0] rd);
    i_req     = ir;
    i_addr    = ia;
    d_req     = dr;
    d_we      = dw;
    d_be      = db;
    d_addr    = da;
    d_wdata   = dd;
    mem_ready = rdy;
    mem_rdata = rd;
  endtask

  // One clock: check just after the negedge, advance the model on the posedge.
  task automatic run_cycle();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  int ready_pct;
  int pct_table[4] = '{5, 30, 60, 100};

  initial begin
    rst = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    compare_all();
    check_output("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Fetch only, memory answers in the first busy cycle.
    apply_stimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    apply_stimulus(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h13);
    run_cycle();
    apply_stimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_output("t1_imem_stall", 32'(imem_stall), 32'h0);
    check_output("t1_i_rdata", i_rdata, 32'h13);
    run_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();

    // Simultaneous fetch and load: data side first.
    apply_stimulus(1, 32'h200, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    run_cycle();
    apply_stimulus(1, 32'h200, 1, 0, 4'hF, 32'h100, 0, 1, 32'hCAFE0100);
    #1;
    check_output("t2_first_addr", mem_addr, 32'h100);
    run_cycle();
    apply_stimulus(1, 32'h200, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    #1;
    check_output("t2_dstall_after_d", 32'(dmem_stall), 32'h0);
    check_output("t2_istall_after_d", 32'(imem_stall), 32'h1);
    run_cycle();
    apply_stimulus(1, 32'h200, 1, 0, 4'hF, 32'h100, 0, 1, 32'h93);
    #1;
    check_output("t2_second_addr", mem_addr, 32'h200);
    run_cycle();
    apply_stimulus(1, 32'h200, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    #1;
    check_output("t2_istall_done", 32'(imem_stall), 32'h0);
    check_output("t2_dstall_done", 32'(dmem_stall), 32'h0);
    check_output("t2_d_rdata", d_rdata, 32'hCAFE0100);
    check_output("t2_i_rdata", i_rdata, 32'h93);
    run_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();

    // Partial store leaves load data untouched.
    apply_stimulus(0, 0, 1, 1, 4'b0011, 32'h104, 32'hDEADBEEF, 0, 0);
    run_cycle();
    apply_stimulus(0, 0, 1, 1, 4'b0011, 32'h104, 32'hDEADBEEF, 1, 32'h55555555);
    #1;
    check_output("t3_mem_we", 32'(mem_we), 32'h1);
    check_output("t3_mem_be", 32'(mem_be), 32'h3);
    check_output("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    run_cycle();
    apply_stimulus(0, 0, 1, 1, 4'b0011, 32'h104, 32'hDEADBEEF, 0, 0);
    #1;
    check_output("t3_dstall", 32'(dmem_stall), 32'h0);
    check_output("t3_d_rdata", d_rdata, 32'hCAFE0100);
    run_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();

    // Load that never gets mem_ready: watchdog forces completion.
    apply_stimulus(0, 0, 1, 0, 4'hF, 32'h108, 0, 0, 0);
    run_cycle();
    for (int k = 0; k < TIMEOUT; k++) run_cycle();
    #1;
    check_output("t4_mem_req", 32'(mem_req), 32'h0);
    check_output("t4_mem_err", 32'(mem_err), 32'h1);
    check_output("t4_d_rdata", d_rdata, 32'h0);
    check_output("t4_dstall", 32'(dmem_stall), 32'h0);
    run_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();

    // Load flushed mid-transaction: data captured, no done flag, fetch granted next.
    apply_stimulus(0, 0, 1, 0, 4'hF, 32'h10C, 0, 0, 0);
    run_cycle();
    apply_stimulus(1, 32'h300, 0, 0, 4'hF, 32'h10C, 0, 0, 0);
    run_cycle();
    apply_stimulus(1, 32'h300, 0, 0, 4'hF, 32'h10C, 0, 1, 32'hABCD0001);
    run_cycle();
    apply_stimulus(1, 32'h300, 0, 0, 4'hF, 32'h10C, 0, 0, 0);
    #1;
    check_output("t5_d_rdata", d_rdata, 32'hABCD0001);
    check_output("t5_mem_req_idle", 32'(mem_req), 32'h0);
    run_cycle();
    apply_stimulus(1, 32'h300, 1, 0, 4'hF, 32'h10C, 0, 0, 0);
    #1;
    check_output("t5_fetch_addr", mem_addr, 32'h300);
    check_output("t5_dstall_rerequest", 32'(dmem_stall), 32'h1);
    run_cycle();
    apply_stimulus(1, 32'h300, 1, 0, 4'hF, 32'h10C, 0, 1, 32'h77);
    run_cycle();
    apply_stimulus(1, 32'h300, 1, 0, 4'hF, 32'h10C, 0, 0, 0);
    run_cycle();
    apply_stimulus(1, 32'h300, 1, 0, 4'hF, 32'h10C, 0, 1, 32'h88);
    run_cycle();
    apply_stimulus(1, 32'h300, 1, 0, 4'hF, 32'h10C, 0, 0, 0);
    run_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();

    // Reset asserted during a fetch.
    apply_stimulus(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    #1;
    check_output("t6_mem_req_busy", 32'(mem_req), 32'h1);
    #1;
    rst = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_output("t6_mem_req_rst", 32'(mem_req), 32'h0);
    check_output("t6_mem_addr_rst", mem_addr, 32'h0);
    check_output("t6_mem_err_rst", 32'(mem_err), 32'h0);
    check_output("t6_i_rdata_rst", i_rdata, 32'h0);
    check_output("t6_d_rdata_rst", d_rdata, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run_cycle();

    // Random pipeline traffic with varying memory responsiveness.
    ready_pct  = 30;
    m_last_adv = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) ready_pct = pct_table[$urandom_range(0, 3)];
      if (m_last_adv) begin
        i_req   = ($urandom_range(0, 9) < 8);
        d_req   = ($urandom_range(0, 9) < 4);
        i_addr  = $urandom & 32'hFFFF_FFFC;
        d_addr  = $urandom;
        d_we    = $urandom_range(0, 1) == 1;
        d_be    = 4'($urandom);
        d_wdata = $urandom;
      end else begin
        if ($urandom_range(0, 99) < 4) i_req = ~i_req;
        if ($urandom_range(0, 99) < 4) d_req = ~d_req;
        if ($urandom_range(0, 99) < 5) i_addr = $urandom;
        if ($urandom_range(0, 99) < 5) d_addr = $urandom;
      end
      mem_ready = ($urandom_range(0, 99) < ready_pct);
      mem_rdata = $urandom;
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
